gemm_tile_controller: RTL and testbench

Parametrised successor of the single-MAC GeMM controller. Sequences tiled GeMM loops for a TileM x TileN x TileK MAC array, producing M/N/K tile counters for address generation in the accelerator top. Adds a selectable outer-loop order, a per-tile output ready/valid handshake with backpressure, an accumulator-clear strobe and zero-size error detection. Sits between the CSR/start logic and the SRAM address generators.

---
 rtl/gemm_tile_controller.sv | 185 ++++++++++++++++++
 tb/tb_gemm_tile_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_controller.sv
// GeMM tile-loop sequencer: walks M/N tile indices and K steps for a
// TileM x TileN x TileK MAC array, with per-tile result handshake,
// accumulator-clear strobe, selectable outer-loop order and zero-size error.
module gemm_tile_controller #(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned TileM     = 4,
    parameter int unsigned TileN     = 16,
    parameter int unsigned TileK     = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 input_valid_i,
    input  logic                 result_ready_i,
    input  logic                 loop_order_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    output logic                 result_valid_o,
    output logic                 acc_clear_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] K_count_o,
    output logic [AddrWidth-1:0] N_count_o
);

    // Tile counts carry one extra bit so ceil() of an all-ones size cannot wrap.
    localparam int unsigned CntW = AddrWidth + 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DRAIN,
        FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] m_cnt_q, m_cnt_d;
    logic [AddrWidth-1:0] n_cnt_q, n_cnt_d;
    logic [AddrWidth-1:0] k_cnt_q, k_cnt_d;
    logic [CntW-1:0]      mt_q, mt_d;
    logic [CntW-1:0]      nt_q, nt_d;
    logic [CntW-1:0]      kt_q, kt_d;
    logic                 order_q, order_d;

    logic zero_size;
    logic last_m;
    logic last_n;
    logic last_k;

    // Number of tiles covering size elements, partial edge tile rounded up.
    function automatic logic [CntW-1:0] ceil_div(input logic [AddrWidth-1:0] size,
                                                 input int unsigned tile);
        logic [CntW-1:0] sum;
        sum = {1'b0, size} + CntW'(tile - 1);
        return sum / CntW'(tile);
    endfunction

    assign zero_size = (M_size_i == '0) | (N_size_i == '0) | (K_size_i == '0);
    assign last_m    = ({1'b0, m_cnt_q} == (mt_q - CntW'(1)));
    assign last_n    = ({1'b0, n_cnt_q} == (nt_q - CntW'(1)));
    assign last_k    = ({1'b0, k_cnt_q} == (kt_q - CntW'(1)));

    assign M_count_o = m_cnt_q;
    assign N_count_o = n_cnt_q;
    assign K_count_o = k_cnt_q;

    // Next-state, counter update and output decode.
    always_comb begin
        state_d        = state_q;
        m_cnt_d        = m_cnt_q;
        n_cnt_d        = n_cnt_q;
        k_cnt_d        = k_cnt_q;
        mt_d           = mt_q;
        nt_d           = nt_q;
        kt_d           = kt_q;
        order_d        = order_q;
        result_valid_o = 1'b0;
        acc_clear_o    = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        error_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (zero_size) begin
                        error_o = 1'b1;
                    end else begin
                        mt_d    = ceil_div(M_size_i, TileM);
                        nt_d    = ceil_div(N_size_i, TileN);
                        kt_d    = ceil_div(K_size_i, TileK);
                        order_d = loop_order_i;
                        m_cnt_d = '0;
                        n_cnt_d = '0;
                        k_cnt_d = '0;
                        state_d = COMPUTE;
                    end
                end
            end

            COMPUTE: begin
                busy_o      = 1'b1;
                acc_clear_o = input_valid_i & (k_cnt_q == '0);
                if (input_valid_i) begin
                    if (last_k) begin
                        state_d = DRAIN;
                    end else begin
                        k_cnt_d = k_cnt_q + AddrWidth'(1);
                    end
                end
            end

            DRAIN: begin
                busy_o         = 1'b1;
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    k_cnt_d = '0;
                    if (last_m && last_n) begin
                        // Last tile handed off: return indices to zero for Finish.
                        m_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = FINISH;
                    end else begin
                        state_d = COMPUTE;
                        if (!order_q) begin
                            if (last_n) begin
                                n_cnt_d = '0;
                                m_cnt_d = m_cnt_q + AddrWidth'(1);
                            end else begin
                                n_cnt_d = n_cnt_q + AddrWidth'(1);
                            end
                        end else begin
                            if (last_m) begin
                                m_cnt_d = '0;
                                n_cnt_d = n_cnt_q + AddrWidth'(1);
                            end else begin
                                m_cnt_d = m_cnt_q + AddrWidth'(1);
                            end
                        end
                    end
                end
            end

            FINISH: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                m_cnt_d = '0;
                n_cnt_d = '0;
                k_cnt_d = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and latched-configuration registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            m_cnt_q <= '0;
            n_cnt_q <= '0;
            k_cnt_q <= '0;
            mt_q    <= '0;
            nt_q    <= '0;
            kt_q    <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_cnt_q <= m_cnt_d;
            n_cnt_q <= n_cnt_d;
            k_cnt_q <= k_cnt_d;
            mt_q    <= mt_d;
            nt_q    <= nt_d;
            kt_q    <= kt_d;
            order_q <= order_d;
        end
    end

endmodule

// File: tb/tb_gemm_tile_controller.sv
// Bench for gemm_tile_controller: tile-list reference model checked every
// cycle, plus directed scenarios with hand-computed timing and tile order.
module tb_gemm_tile_controller;

    localparam int AW = 16;
    localparam int TM = 4;
    localparam int TN = 16;
    localparam int TK = 1;

    logic          clk = 1'b0;
    logic          rst, start, iv, rr, lo;
    logic [AW-1:0] ms, ks, ns;
    logic          rv_o, acc_o, busy_o, done_o, err_o;
    logic [AW-1:0] m_o, k_o, n_o;

    gemm_tile_controller #(.AddrWidth(AW), .TileM(TM), .TileN(TN), .TileK(TK)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .input_valid_i(iv),
        .result_ready_i(rr), .loop_order_i(lo), .M_size_i(ms), .K_size_i(ks),
        .N_size_i(ns), .result_valid_o(rv_o), .acc_clear_o(acc_o), .busy_o(busy_o),
        .done_o(done_o), .error_o(err_o), .M_count_o(m_o), .K_count_o(k_o),
        .N_count_o(n_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 result offered, 3 done.
    // The current tile is derived from its position in the tile sequence.
    int ph = 0, kc = 0, tidx = 0, mt = 0, nt = 0, kt = 0, ord = 0;
    int hs_cnt = 0, max_m = 0, max_n = 0, max_k = 0;
    int hs_m[$];
    int hs_n[$];

    function automatic int tile_m(int idx);
        return (ord == 0) ? idx / nt : idx % mt;
    endfunction
    function automatic int tile_n(int idx);
        return (ord == 0) ? idx % nt : idx / mt;
    endfunction

    initial begin : compare
        logic [52:0] expv, actv;
        int em, en, ek;
        forever begin
            @(negedge clk);
            em = 0; en = 0; ek = 0;
            if (ph == 1 || ph == 2) begin
                em = tile_m(tidx);
                en = tile_n(tidx);
                ek = kc;
            end
            expv = {ph != 0, ph == 2, ph == 3,
                    ph == 0 && start && (ms == 0 || ns == 0 || ks == 0),
                    ph == 1 && iv && kc == 0,
                    AW'(em), AW'(en), AW'(ek)};
            actv = {busy_o, rv_o, done_o, err_o, acc_o, m_o, n_o, k_o};
            chk("model_outputs", 64'(actv), 64'(expv));
            if (rv_o === 1'b1 && rr) begin
                hs_cnt++;
                hs_m.push_back(int'(m_o));
                hs_n.push_back(int'(n_o));
            end
            if (int'(m_o) > max_m) max_m = int'(m_o);
            if (int'(n_o) > max_n) max_n = int'(n_o);
            if (int'(k_o) > max_k) max_k = int'(k_o);
            if (rst) begin
                ph = 0; kc = 0; tidx = 0;
            end else begin
                case (ph)
                    0: if (start && ms != 0 && ns != 0 && ks != 0) begin
                        mt = (int'(ms) + TM - 1) / TM;
                        nt = (int'(ns) + TN - 1) / TN;
                        kt = (int'(ks) + TK - 1) / TK;
                        ord = int'(lo); kc = 0; tidx = 0; ph = 1;
                    end
                    1: if (iv) begin
                        if (kc == kt - 1) ph = 2;
                        else kc++;
                    end
                    2: if (rr) begin
                        kc = 0;
                        if (tidx == mt * nt - 1) ph = 3;
                        else begin tidx++; ph = 1; end
                    end
                    default: begin ph = 0; tidx = 0; end
                endcase
            end
        end
    end

    task automatic clear_log();
        hs_cnt = 0; max_m = 0; max_n = 0; max_k = 0;
        hs_m.delete(); hs_n.delete();
    endtask

    // Start one operation and return the cycle offset of done_o (-1 on timeout).
    task automatic run_op(input int m, input int n, input int k, input bit order,
                          input bit extra_start, output int rel);
        int s;
        @(posedge clk); #1;
        ms = AW'(m); ns = AW'(n); ks = AW'(k); lo = order; start = 1'b1; s = cyc;
        @(posedge clk); #1;
        start = 1'b0; ms = 3; ns = 5; ks = 7; lo = ~order;
        rel = -1;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk); #1;
            start = extra_start && (cyc - s == 3);
            if (done_o === 1'b1) begin rel = cyc - s; break; end
        end
        start = 1'b0;
        if (rel < 0) chk("done_timeout", 64'(rel), 64'd0);
    endtask

    initial begin : stim
        int rel, s;
        int e0m[4] = '{0, 0, 1, 1};
        int e0n[4] = '{0, 1, 0, 1};
        rst = 1'b1; start = 1'b0; iv = 1'b1; rr = 1'b1; lo = 1'b0;
        ms = '0; ns = '0; ks = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({busy_o, rv_o, done_o, acc_o, m_o, n_o, k_o}), 64'd0);
        rst = 1'b0;

        // Single tile, K=8: literal cycle timeline.
        @(posedge clk); #1;
        ms = 4; ns = 16; ks = 8; lo = 0; start = 1'b1; s = cyc;
        for (int r = 1; r <= 11; r++) begin
            @(posedge clk); #1;
            start = 1'b0;
            chk("t1_acc_clear", 64'(acc_o), 64'(r == 1));
            chk("t1_k_count", 64'(k_o), 64'((r <= 8) ? r - 1 : (r == 9) ? 7 : 0));
            chk("t1_result_valid", 64'(rv_o), 64'(r == 9));
            chk("t1_done", 64'(done_o), 64'(r == 10));
            chk("t1_busy", 64'(busy_o), 64'(r <= 10));
        end

        // 2x2 tiles, both loop orders.
        clear_log();
        run_op(8, 32, 2, 1'b0, 1'b0, rel);
        chk("t2_o0_latency", 64'(rel), 64'd13);
        chk("t2_o0_tiles", 64'(hs_m.size()), 64'd4);
        for (int i = 0; i < 4 && i < hs_m.size(); i++) begin
            chk("t2_o0_m", 64'(hs_m[i]), 64'(e0m[i]));
            chk("t2_o0_n", 64'(hs_n[i]), 64'(e0n[i]));
        end
        clear_log();
        run_op(8, 32, 2, 1'b1, 1'b0, rel);
        chk("t2_o1_latency", 64'(rel), 64'd13);
        chk("t2_o1_tiles", 64'(hs_m.size()), 64'd4);
        for (int i = 0; i < 4 && i < hs_m.size(); i++) begin
            chk("t2_o1_m", 64'(hs_m[i]), 64'(e0n[i]));
            chk("t2_o1_n", 64'(hs_n[i]), 64'(e0m[i]));
        end

        // Partial edge tiles, with a start pulse while busy.
        clear_log();
        run_op(5, 17, 3, 1'b0, 1'b1, rel);
        chk("t3_latency", 64'(rel), 64'd17);
        chk("t3_handshakes", 64'(hs_cnt), 64'd4);
        chk("t3_max_counts", 64'({max_m[7:0], max_n[7:0], max_k[7:0]}), 64'h010102);

        // Input stall in Compute, then backpressure in Drain.
        rr = 1'b0;
        @(posedge clk); #1;
        ms = 4; ns = 16; ks = 4; lo = 0; iv = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; iv = 1'b0; #1;
            chk("t4_stall_k", 64'(k_o), 64'd2);
            chk("t4_stall_acc", 64'(acc_o), 64'd0);
        end
        @(posedge clk); #1; iv = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; iv = i[0]; #1;
            chk("t4_bp_valid", 64'(rv_o), 64'd1);
            chk("t4_bp_counts", 64'({m_o, n_o, k_o}), 64'h000000000003);
        end
        @(posedge clk); #1; rr = 1'b1; iv = 1'b1;
        rel = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin rel = i; break; end
        end
        chk("t4_done_after_ready", 64'(rel), 64'd0);

        // Zero size: error pulse only.
        @(posedge clk); #1;
        ms = 16; ns = 16; ks = 0; start = 1'b1; #1;
        chk("t5_error_pulse", 64'({err_o, busy_o}), 64'b10);
        @(posedge clk); #1; start = 1'b0; #1;
        chk("t5_error_cleared", 64'({err_o, busy_o}), 64'b00);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t5_no_done", 64'({done_o, busy_o}), 64'b00);
        end

        // Maximum M size: 16384 M tiles, M inner.
        clear_log();
        run_op(16'hFFFF, 16, 1, 1'b1, 1'b0, rel);
        chk("t5_max_latency", 64'(rel), 64'd32769);
        chk("t5_max_m", 64'(max_m), 64'd16383);

        // Reset mid-Compute, then a normal run.
        @(posedge clk); #1;
        ms = 4; ns = 16; ks = 8; lo = 0; iv = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        rel = -1;
        for (int i = 0; i < 20; i++) begin
            if (k_o === 16'd3) begin rel = i; break; end
            @(posedge clk); #1;
        end
        chk("t6_reached_k3", 64'(rel >= 0), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_after_reset", 64'({busy_o, rv_o, done_o, acc_o, err_o, m_o, n_o, k_o}), 64'd0);
        rst = 1'b0;
        run_op(4, 16, 8, 1'b0, 1'b0, rel);
        chk("t6_rerun_latency", 64'(rel), 64'd10);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
